// File: rtl/press_counter_hexn.sv
// press_counter_hexn: debounced push-button press counter.
// Each accepted press latches the switch bank onto the LEDs and increments
// a DIGITS-wide hex or BCD counter. The counter either wraps or saturates,
// and ovf_o is a sticky flag. Every digit drives an active-low seven-segment display.
module press_counter_hexn #(
    parameter int SW_W            = 10,
    parameter int DIGITS          = 2,
    parameter int BCD_MODE        = 1,
    parameter int SATURATE        = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    input  logic                  key_i,
    input  logic [SW_W-1:0]       sw_i,
    output logic [SW_W-1:0]       ledr_o,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  ovf_o
);

    localparam int CW = 4 * DIGITS;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            stable_dly_q;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW_W-1:0] led_q, led_d;
    logic            ovf_q, ovf_d;
    logic            press_evt;
    logic            cnt_max;

    // One increment step: per-digit decimal carry in BCD mode, plain add otherwise.
    function automatic logic [CW-1:0] incr(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        if (BCD_MODE != 0) begin
            r     = v;
            carry = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (carry) begin
                    if (v[4*k +: 4] == 4'd9) begin
                        r[4*k +: 4] = 4'd0;
                    end else begin
                        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The press event fires once, on the cycle after the debounced level falls.
    assign press_evt = stable_dly_q & ~stable_q;

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DLAST) begin
            stable_d = sync2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Counter/LED/overflow next state; saturate holds at max, wrap relies on incr rolling to 0.
    always_comb begin
        cnt_max = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q[4*k +: 4] != ((BCD_MODE != 0) ? 4'd9 : 4'hF)) cnt_max = 1'b0;
        end
        cnt_d = cnt_q;
        led_d = led_q;
        ovf_d = ovf_q;
        if (press_evt) begin
            led_d = sw_i;
            if (!(cnt_max && (SATURATE != 0))) cnt_d = incr(cnt_q);
            if (cnt_max) ovf_d = 1'b1;
        end
    end

    // Synchroniser and debounce registers; idle level of the key is high.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            dcnt_q       <= '0;
        end else begin
            sync1_q      <= key_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            dcnt_q       <= dcnt_d;
        end
    end

    // Counter, LED latch and sticky overflow; reset wins over a same-cycle event.
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            led_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
            ovf_q <= ovf_d;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign hex_o[7*g +: 7] = seg7(cnt_q[4*g +: 4]);
    end

    assign cnt_o  = cnt_q;
    assign ledr_o = led_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_press_counter_hexn.sv
// Bench for press_counter_hexn: a default BCD/wrap instance and a hex/saturate
// instance share the same key, switch and reset stimulus.
module tb_press_counter_hexn;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key;
    logic [9:0]  sw;

    logic [9:0]  led_b, led_h;
    logic [13:0] hex_b, hex_h;
    logic [7:0]  cnt_b, cnt_h;
    logic        ovf_b, ovf_h;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    press_counter_hexn #(
        .SW_W(10), .DIGITS(2), .BCD_MODE(1), .SATURATE(0), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk100_i(clk), .rstn_i(rstn), .key_i(key), .sw_i(sw),
        .ledr_o(led_b), .hex_o(hex_b), .cnt_o(cnt_b), .ovf_o(ovf_b)
    );

    press_counter_hexn #(
        .SW_W(10), .DIGITS(2), .BCD_MODE(0), .SATURATE(1), .DEBOUNCE_CYCLES(4)
    ) dut_h (
        .clk100_i(clk), .rstn_i(rstn), .key_i(key), .sw_i(sw),
        .ledr_o(led_h), .hex_o(hex_h), .cnt_o(cnt_h), .ovf_o(ovf_h)
    );

    typedef struct {
        int          npress;
        logic [9:0]  sw;
        logic [7:0]  cnt_b;
        logic [13:0] hex_b;
        logic        ovf_b;
        logic [7:0]  cnt_h;
        logic [13:0] hex_h;
        logic        ovf_h;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] s);
        sw  = s;
        key = 1'b0;
        cycles(8);
        key = 1'b1;
        cycles(8);
    endtask

    initial begin
        //                npress sw      cnt_b  hex_b                   ovf_b cnt_h  hex_h                   ovf_h
        vt[0] = '{1,   10'h001, 8'h01, 14'b1000000_1111001, 1'b0, 8'h01, 14'b1000000_1111001, 1'b0};
        vt[1] = '{8,   10'h002, 8'h09, 14'b1000000_0010000, 1'b0, 8'h09, 14'b1000000_0010000, 1'b0};
        vt[2] = '{1,   10'h3C3, 8'h10, 14'b1111001_1000000, 1'b0, 8'h0A, 14'b1000000_0001000, 1'b0};
        vt[3] = '{5,   10'h004, 8'h15, 14'b1111001_0010010, 1'b0, 8'h0F, 14'b1000000_0001110, 1'b0};
        vt[4] = '{84,  10'h155, 8'h99, 14'b0010000_0010000, 1'b0, 8'h63, 14'b0000010_0110000, 1'b0};
        vt[5] = '{1,   10'h2AA, 8'h00, 14'b1000000_1000000, 1'b1, 8'h64, 14'b0000010_0011001, 1'b0};
        vt[6] = '{155, 10'h0F0, 8'h55, 14'b0010010_0010010, 1'b1, 8'hFF, 14'b0001110_0001110, 1'b0};
        vt[7] = '{1,   10'h00F, 8'h56, 14'b0010010_0000010, 1'b1, 8'hFF, 14'b0001110_0001110, 1'b1};
        vt[8] = '{1,   10'h301, 8'h57, 14'b0010010_1111000, 1'b1, 8'hFF, 14'b0001110_0001110, 1'b1};

        // Reset values
        rstn = 1'b0;
        key  = 1'b1;
        sw   = 10'h3FF;
        cycles(3);
        chk("reset_cnt", 32'(cnt_b), 32'h0);
        chk("reset_led", 32'(led_b), 32'h0);
        chk("reset_ovf", 32'(ovf_b), 32'h0);
        chk("reset_hex", 32'(hex_b), 32'(14'b1000000_1000000));
        chk("reset_hex_h", 32'(hex_h), 32'(14'b1000000_1000000));
        rstn = 1'b1;
        cycles(3);

        // Single press: exact update edge and immunity to sw after the event
        sw  = 10'h2A5;
        key = 1'b0;
        cycles(6);
        chk("press_edge6_cnt", 32'(cnt_b), 32'h0);
        chk("press_edge6_led", 32'(led_b), 32'h0);
        cycles(1);
        chk("press_edge7_cnt", 32'(cnt_b), 32'h01);
        chk("press_edge7_led", 32'(led_b), 32'h2A5);
        sw = 10'h155;
        cycles(13);
        key = 1'b1;
        cycles(20);
        chk("release_cnt", 32'(cnt_b), 32'h01);
        chk("release_led", 32'(led_b), 32'h2A5);
        chk("release_hex", 32'(hex_b), 32'(14'b1000000_1111001));

        // Bounce: short glitches are rejected, the final clean press counts once
        sw = 10'h0F0;
        for (int i = 0; i < 30; i++) begin
            key = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            cycles(1);
        end
        chk("bounce_filtered_cnt", 32'(cnt_b), 32'h01);
        chk("bounce_filtered_led", 32'(led_b), 32'h2A5);
        key = 1'b0;
        cycles(20);
        key = 1'b1;
        cycles(20);
        chk("bounce_cnt", 32'(cnt_b), 32'h02);
        chk("bounce_led", 32'(led_b), 32'h0F0);

        // Table: cumulative presses from reset on both instances
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(2);
        for (int v = 0; v < 9; v++) begin
            for (int p = 0; p < vt[v].npress; p++) press(vt[v].sw);
            chk($sformatf("vec%0d_cnt_b", v), 32'(cnt_b), 32'(vt[v].cnt_b));
            chk($sformatf("vec%0d_hex_b", v), 32'(hex_b), 32'(vt[v].hex_b));
            chk($sformatf("vec%0d_ovf_b", v), 32'(ovf_b), 32'(vt[v].ovf_b));
            chk($sformatf("vec%0d_cnt_h", v), 32'(cnt_h), 32'(vt[v].cnt_h));
            chk($sformatf("vec%0d_hex_h", v), 32'(hex_h), 32'(vt[v].hex_h));
            chk($sformatf("vec%0d_ovf_h", v), 32'(ovf_h), 32'(vt[v].ovf_h));
            chk($sformatf("vec%0d_led_b", v), 32'(led_b), 32'(vt[v].sw));
            chk($sformatf("vec%0d_led_h", v), 32'(led_h), 32'(vt[v].sw));
        end

        // Reset mid-press with the event pending, key held through reset release
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(2);
        for (int p = 0; p < 5; p++) press(10'h011);
        chk("midrst_pre_cnt", 32'(cnt_b), 32'h05);
        key = 1'b0;
        cycles(6);
        rstn = 1'b0;
        cycles(2);
        chk("midrst_cnt_b", 32'(cnt_b), 32'h0);
        chk("midrst_cnt_h", 32'(cnt_h), 32'h0);
        chk("midrst_led", 32'(led_b), 32'h0);
        chk("midrst_ovf_h", 32'(ovf_h), 32'h0);
        rstn = 1'b1;
        cycles(6);
        chk("midrst_edge6_cnt", 32'(cnt_b), 32'h0);
        cycles(1);
        chk("midrst_edge7_cnt_b", 32'(cnt_b), 32'h01);
        chk("midrst_edge7_cnt_h", 32'(cnt_h), 32'h01);
        chk("midrst_edge7_led", 32'(led_b), 32'h011);
        key = 1'b1;
        cycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/press_counter_hexn.md
# press_counter_hexn

Parametrised successor of the lab 2 switch/press counter. Each debounced press of a board push-button does two things: it latches the switch bank onto the LEDs and increments a multi-digit counter. The counter drives N seven-segment digits, in hex or decimal (BCD), with wrap or saturate overflow and a sticky overflow flag. It sits between the raw board I/O (switches, key, LEDs, HEX) and is the template for all later counting labs.

## Interface
Parameters:
- SW_W, 10: width of switch input and LED output.
- DIGITS, 2: number of seven-segment digits (1..8); counter width is 4*DIGITS.
- BCD_MODE, 1: 1 = each digit counts 0..9 (decimal); 0 = each digit counts 0..F (binary).
- SATURATE, 0: 1 = counter holds at maximum; 0 = counter wraps to zero.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a key level is accepted (>=1).

Ports:
- clk100_i, input, 1: system clock, all logic on the rising edge.
- rstn_i, input, 1: reset, synchronous, active-low.
- key_i, input, 1: push-button, active-low (0 = pressed), asynchronous to clk100_i.
- sw_i, input, SW_W: switch bank.
- ledr_o, output, SW_W: switch value latched at the last accepted press.
- hex_o, output, 7*DIGITS: segments, active-low, digit k at [7k+6:7k] with digit 0 = least significant; bit order {g,f,e,d,c,b,a}.
- cnt_o, output, 4*DIGITS: raw counter value (BCD-packed when BCD_MODE=1).
- ovf_o, output, 1: sticky overflow flag.

## Operation
- Synchronisation: key_i passes through a 2-FF synchroniser (reset value 1); its output is key_sync.
- Debounce:
  - key_stable has reset value 1; the counter dcnt has reset value 0.
  - If key_sync equals key_stable, dcnt is cleared to 0.
  - Otherwise dcnt increments. When dcnt == DEBOUNCE_CYCLES-1 and the levels still differ, key_stable <= key_sync and dcnt <= 0.
- Press event: key_stable_d is key_stable delayed by one register (reset value 1). The event is key_stable_d & ~key_stable, a one-cycle pulse. Release produces no event.
- On each event:
  - ledr_o <= sw_i as sampled in the event cycle.
  - The counter increments by one.
- Increment rules:
  - BCD_MODE=1: digit 0 increments. Any digit at 9 becomes 0 and carries into the next digit.
  - BCD_MODE=0: plain binary add over 4*DIGITS bits.
- Overflow occurs when the count is at its maximum (all 9s, or all Fs) and an event arrives:
  - SATURATE=0: the count becomes 0 and ovf_o <= 1.
  - SATURATE=1: the count is held and ovf_o <= 1.
  - ovf_o clears only on reset.
- Display:
  - Each digit is decoded combinationally from cnt_o. Active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - In BCD mode, digit codes A..F cannot occur.
- Reset (rstn_i=0 at a rising edge) values:
  - cnt_o=0, ledr_o=0, ovf_o=0.
  - Every hex digit shows 1000000 ("0").
  - Synchroniser, key_stable and key_stable_d are all 1; dcnt=0.
- Reset mid-debounce or mid-press discards the pending state. A key held low through reset release is accepted as a new press after the normal latency.

## Timing
- Press latency: number edges from the first rising edge at which key_i is sampled low as edge 1. The clean press is accepted at edge 2+DEBOUNCE_CYCLES. The event pulse is high in the following cycle. cnt_o, ledr_o and ovf_o update at edge 3+DEBOUNCE_CYCLES. hex_o follows cnt_o combinationally in the same cycle.
- Glitch filtering: a glitch in which key_sync differs for fewer than DEBOUNCE_CYCLES consecutive cycles produces no event and no output change.
- Rate limit: at most one increment per accepted press. The minimum spacing between events is 2*DEBOUNCE_CYCLES cycles, because a press and a release must each be accepted.
- sw_i: no setup requirement beyond a single clock. Changes of sw_i outside event cycles have no effect.
- Reset priority: reset has priority over an event in the same cycle.

## Test plan
- Reset: rstn_i=0 for 3 cycles with key_i=1 and sw_i=10'h3FF -> cnt_o=0, ledr_o=0, ovf_o=0, hex_o={1000000,1000000}.
- Single press, DEBOUNCE_CYCLES=4: sw_i=10'h2A5, key_i low for 20 cycles then high -> cnt_o=0x01 and ledr_o=10'h2A5 exactly at edge 7, with no further change on release.
- Bounce: key_i toggling low/high every 2 cycles for 30 cycles, then low for 20 cycles -> exactly one increment.
- Decimal carry, BCD_MODE=1, DIGITS=2: 10 presses -> cnt_o=0x10, hex_o={1111001,1000000}. 100 presses total with SATURATE=0 -> cnt_o=0x00 and ovf_o=1.
- Hex/saturate, BCD_MODE=0, SATURATE=1: 256 presses -> cnt_o=0xFF, ovf_o=1, hex_o={0001110,0001110}. A 257th press keeps 0xFF.
- Reset mid-operation: rstn_i=0 while key_stable has just gone low and cnt_o=0x05 -> cnt_o=0. Key still held after rstn_i=1 -> cnt_o=0x01 at edge 3+DEBOUNCE_CYCLES after release.
